// File: rtl/aes_enc_sequencer.sv
// ---------------------------------------------------------------------------
// aes_enc_sequencer
//
// Iterative AES-128 encryption controller. It accepts one plaintext/key pair,
// then reuses a single round datapath for Nr cycles while stepping through a
// combinational key schedule. It returns the ciphertext over a valid/ready
// handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   plaintext/key offered
//   in_ready   sequencer can accept a block (IDLE only)
//   in_data    plaintext [0:127], bit 0 is the MSB of byte 0
//   in_key     cipher key, same ordering as in_data
//   out_valid  ciphertext available (DONE only)
//   out_ready  consumer accepts the ciphertext
//   out_data   ciphertext, driven from state_q in every state
//   busy       high in ROUND or FINAL
//   abort      terminate the block in flight (only with AES_ABORT_EN)
//
// Build option:
//   AES_ABORT_EN  adds the abort input. Without it, only rst ends a block.
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for a plaintext/key pair, in_ready high
//   ROUND | full rounds 1..Nr-1 (SubBytes, ShiftRows, MixColumns, AddRoundKey)
//   FINAL | last round, no MixColumns
//   DONE  | ciphertext presented, waiting for out_ready
// ---------------------------------------------------------------------------
module aes_enc_sequencer #(
    parameter int Nr = 10,
    parameter int N  = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:N-1] in_data,
    input  logic [0:N-1] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:N-1] out_data,
    output logic         busy
`ifdef AES_ABORT_EN
    ,
    input  logic         abort
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [0:N-1] state_q, state_d;
    logic [0:N-1] key_q, key_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [0:N-1] rk_all [0:Nr];
    logic [0:N-1] round_key;
    logic [0:N-1] sub_shift_out;
    logic [0:N-1] round_full;
    logic [0:N-1] round_last;

    // ------------------------------------------------------------------
    // GF(2^8) helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (x^254, with 0 -> 0)
    // followed by the affine transform, instead of a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // ------------------------------------------------------------------
    // Round primitives; byte i of the block is row i%4, column i/4
    // ------------------------------------------------------------------
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r+4*c) +: 8] = sbox(s[8*(r+4*((c+r)%4)) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Key schedule: expanded entirely from key_q, in parallel with the
    // round datapath, so only the round-key mux sits in the round path.
    // ------------------------------------------------------------------
    always_comb begin
        logic [31:0] w [0:4*Nr+3];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) begin
            w[i] = key_q[32*i +: 32];
        end
        for (int i = 4; i < 4*Nr+4; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]) ^ rcon, sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= Nr; r++) begin
            rk_all[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    end

    assign round_key     = rk_all[rnd_q];
    assign sub_shift_out = sub_shift(state_q);
    assign round_full    = mix_columns(sub_shift_out) ^ round_key;
    assign round_last    = sub_shift_out ^ round_key;

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        key_d     = key_q;
        rnd_d     = rnd_q;
        in_ready  = (fsm_q == IDLE);
        out_valid = (fsm_q == DONE);
        busy      = (fsm_q == ROUND) || (fsm_q == FINAL);

        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    key_d   = in_key;
                    state_d = in_data ^ in_key;
                    rnd_d   = 4'd1;
                    fsm_d   = (Nr > 1) ? ROUND : FINAL;
                end
            end
            ROUND: begin
                state_d = round_full;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == 4'(Nr - 1)) fsm_d = FINAL;
            end
            FINAL: begin
                state_d = round_last;
                fsm_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                    rnd_d = 4'd0;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

`ifdef AES_ABORT_EN
        // Abort drops the block but keeps state_q, so out_data does not
        // glitch back to zero.
        if (abort && (fsm_q != IDLE)) begin
            fsm_d   = IDLE;
            rnd_d   = 4'd0;
            state_d = state_q;
            key_d   = key_q;
        end
`endif
    end

    assign out_data = state_q;

endmodule

// File: tb/tb_aes_enc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_enc_sequencer
//
// Directed bench for aes_enc_sequencer using the FIPS-197 vectors: single
// block, backpressure, back-to-back blocks with a key change in flight,
// reset mid-block and (with AES_ABORT_EN) abort mid-block.
// ---------------------------------------------------------------------------
module tb_aes_enc_sequencer;

    localparam logic [0:127] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:127] in_data = '0;
    logic [0:127] in_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:127] out_data;
    logic         busy;
`ifdef AES_ABORT_EN
    logic         abort = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    aes_enc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef AES_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block, wait for the ciphertext, optionally stall the
    // consumer for n_stall cycles, then complete the handshake.
    task automatic run_block(input string tag, input logic [0:127] k, input logic [0:127] p,
                             input logic [0:127] c, input int n_stall);
        int g;
        int lat;
        in_data   = p;
        in_key    = k;
        in_valid  = 1'b1;
        out_ready = (n_stall == 0);
        g = 0;
        while (!in_ready && g < 30) begin
            tick();
            g++;
        end
        chk({tag, " in_ready before accept"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_key   = ~k;
        in_data  = ~p;
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
            if (lat == 5) begin
                chk({tag, " busy mid-block"}, busy, 1);
                chk({tag, " in_ready mid-block"}, in_ready, 0);
            end
        end
        // out_valid rises after edge k+Nr, i.e. Nr edges after acceptance.
        chk({tag, " edges to out_valid"}, lat, 10);
        chk({tag, " ciphertext"}, out_data, c);
        chk({tag, " busy in DONE"}, busy, 0);
        for (int i = 0; i < n_stall; i++) begin
            tick();
            chk({tag, " stalled out_data"}, out_data, c);
            chk({tag, " stalled in_ready"}, in_ready, 0);
            chk({tag, " stalled out_valid"}, out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        chk({tag, " out_valid after handshake"}, out_valid, 0);
        chk({tag, " in_ready after handshake"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:127] outs [0:1];
        int           acc_t [0:1];
        int           out_t0;
        int           n_acc;
        int           n_out;
        int           t;
        int           ov_seen;
        logic         acc;
        logic         ov;
        logic [0:127] od;

        tick();
        tick();
        rst = 1'b0;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset out_data", out_data, 0);

        run_block("C1", K1, P1, C1, 0);
        run_block("B backpressure", K2, P2, C2, 5);

        // Back-to-back: in_valid stays high; vectors switch to App. B three
        // edges into the first block.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = P1;
        in_key    = K1;
        n_acc  = 0;
        n_out  = 0;
        t      = 0;
        out_t0 = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        outs[0]  = '0;
        outs[1]  = '0;
        while (n_out < 2 && t < 60) begin
            acc = in_valid && in_ready;
            ov  = out_valid && out_ready;
            od  = out_data;
            tick();
            t++;
            if (acc && n_acc < 2) begin
                acc_t[n_acc] = t;
                n_acc++;
                if (n_acc == 2) in_valid = 1'b0;
            end
            if (ov && n_out < 2) begin
                outs[n_out] = od;
                if (n_out == 0) out_t0 = t;
                n_out++;
            end
            if (n_acc == 1 && t == acc_t[0] + 3) begin
                in_data = P2;
                in_key  = K2;
            end
        end
        chk("b2b acceptances", n_acc, 2);
        chk("b2b outputs", n_out, 2);
        chk("b2b acceptance interval", acc_t[1] - acc_t[0], 12);
        chk("b2b first handshake latency", out_t0 - acc_t[0], 11);
        chk("b2b first ciphertext", outs[0], C1);
        chk("b2b second ciphertext", outs[1], C2);

        // Reset while rnd_q = 5.
        tick();
        in_data  = P1;
        in_key   = K1;
        in_valid = 1'b1;
        chk("rst test in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst test busy in round 5", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-block reset in_ready", in_ready, 1);
        chk("mid-block reset out_valid", out_valid, 0);
        chk("mid-block reset busy", busy, 0);
        chk("mid-block reset out_data", out_data, 0);
        run_block("C1 after reset", K1, P1, C1, 0);

`ifdef AES_ABORT_EN
        // Abort while rnd_q = 3.
        in_data  = P1;
        in_key   = K1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort test busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort in_ready", in_ready, 1);
        chk("abort busy", busy, 0);
        chk("abort out_valid", out_valid, 0);
        ov_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        chk("abort no out_valid", ov_seen, 0);
        run_block("B after abort", K2, P2, C2, 0);
`else
        ov_seen = 0;
        chk("idle out_valid", out_valid, ov_seen);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
